// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the register-file / ALU / write-back-mux datapath.
// Each accepted command walks IDLE -> READ -> EXEC -> WB -> RESP; literal writes skip READ/EXEC.
module alu_seq_ctrl #(
  parameter int unsigned EXEC_WAIT = 1
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [4:0]  cmd_rs,
  input  logic [4:0]  cmd_rt,
  input  logic [4:0]  cmd_rd,
  input  logic [4:0]  cmd_shamt,
  input  logic        cmd_src,
  input  logic [31:0] cmd_imm,
  output logic [4:0]  RR1,
  output logic [4:0]  RR2,
  output logic [4:0]  WR,
  output logic [31:0] WD,
  output logic        WE,
  output logic [3:0]  AluOp,
  output logic [4:0]  ShiftCount,
  output logic        Mux_Ctrl,
  input  logic [31:0] AluResult,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  state_t      r_state;
  logic [4:0]  r_rd;
  logic        r_src;
  logic [31:0] r_imm;
  logic [31:0] r_result;
  logic [3:0]  r_cnt;

  function automatic logic f_legal(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
      4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

  // Gated by Rst_n so no command can be handshaken while reset is held.
  assign cmd_ready = Rst_n && (r_state == S_IDLE);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_rd       <= '0;
      r_src      <= 1'b0;
      r_imm      <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      RR1        <= '0;
      RR2        <= '0;
      WR         <= '0;
      WD         <= '0;
      WE         <= 1'b0;
      AluOp      <= '0;
      ShiftCount <= '0;
      Mux_Ctrl   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_rd     <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_rd  <= cmd_rd;
            r_src <= cmd_src;
            r_imm <= cmd_imm;
            if (!cmd_src) begin
              r_state  <= S_WB;
              WE       <= 1'b1;
              WR       <= cmd_rd;
              WD       <= cmd_imm;
              Mux_Ctrl <= 1'b0;
            end else if (f_legal(cmd_op)) begin
              r_state    <= S_READ;
              RR1        <= cmd_rs;
              RR2        <= cmd_rt;
              AluOp      <= cmd_op;
              ShiftCount <= cmd_shamt;
            end else begin
              r_state   <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rd    <= cmd_rd;
              rsp_data  <= '0;
            end
          end
        end
        S_READ: begin
          r_state <= S_EXEC;
          r_cnt   <= 4'(EXEC_WAIT - 1);
        end
        S_EXEC: begin
          // Result is captured on the closing edge of the last settling cycle.
          if (r_cnt == 4'd0) begin
            r_result <= AluResult;
            r_state  <= S_WB;
            WE       <= 1'b1;
            WR       <= r_rd;
            WD       <= r_imm;
            Mux_Ctrl <= r_src;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_WB: begin
          WE        <= 1'b0;
          r_state   <= S_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rd    <= r_rd;
          rsp_data  <= r_src ? r_result : r_imm;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with behavioural register-file and ALU models.
// Two instances: EXEC_WAIT=1 for the main sequence, EXEC_WAIT=3 for the stall test.
module tb_alu_seq_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_valid3 = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [4:0]  cmd_rs = '0, cmd_rt = '0, cmd_rd = '0, cmd_shamt = '0;
  logic        cmd_src = 1'b0;
  logic [31:0] cmd_imm = '0;
  logic        rsp_ready = 1'b1;
  logic        rsp_ready3 = 1'b1;

  logic        cmd_ready, WE, Mux_Ctrl, rsp_valid, rsp_err;
  logic [4:0]  RR1, RR2, WR, ShiftCount, rsp_rd;
  logic [3:0]  AluOp;
  logic [31:0] WD, AluResult, rsp_data;

  logic        cmd_ready_3, WE_3, Mux_Ctrl_3, rsp_valid_3, rsp_err_3;
  logic [4:0]  RR1_3, RR2_3, WR_3, ShiftCount_3, rsp_rd_3;
  logic [3:0]  AluOp_3;
  logic [31:0] WD_3, AluResult_3, rsp_data_3;

  logic [31:0] rf  [32];
  logic [31:0] rf3 [32];
  logic        rf_loaded = 1'b0;
  int          we_count = 0;
  int          total = 0;
  int          bad = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return {31'b0, $signed(a) < $signed(b)};
      4'b1000: return {31'b0, a < b};
      4'b1100: return ~(a | b);
      4'b1101: return a << sh;
      4'b1110: return a >> sh;
      4'b1111: return 32'($signed(a) >>> sh);
      default: return 32'h0;
    endcase
  endfunction

  assign AluResult   = alu_f(AluOp, rf[RR1], rf[RR2], ShiftCount);
  assign AluResult_3 = alu_f(AluOp_3, rf3[RR1_3], rf3[RR2_3], ShiftCount_3);

  // Register files start out holding their own index.
  always @(posedge Clk) begin
    if (!rf_loaded) begin
      for (int i = 0; i < 32; i++) begin
        rf[i]  <= 32'(i);
        rf3[i] <= 32'(i);
      end
      rf_loaded <= 1'b1;
    end else begin
      if (WE)   rf[WR]    <= Mux_Ctrl ? AluResult : WD;
      if (WE_3) rf3[WR_3] <= Mux_Ctrl_3 ? AluResult_3 : WD_3;
    end
  end

  always @(posedge Clk) if (WE === 1'b1) we_count <= we_count + 1;

  alu_seq_ctrl #(.EXEC_WAIT(1)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .RR1(RR1), .RR2(RR2), .WR(WR), .WD(WD), .WE(WE), .AluOp(AluOp),
    .ShiftCount(ShiftCount), .Mux_Ctrl(Mux_Ctrl), .AluResult(AluResult),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_err(rsp_err)
  );

  alu_seq_ctrl #(.EXEC_WAIT(3)) u_dut3 (
    .Clk(Clk), .Rst_n(Rst_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready_3),
    .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_shamt(cmd_shamt), .cmd_src(cmd_src), .cmd_imm(cmd_imm),
    .RR1(RR1_3), .RR2(RR2_3), .WR(WR_3), .WD(WD_3), .WE(WE_3), .AluOp(AluOp_3),
    .ShiftCount(ShiftCount_3), .Mux_Ctrl(Mux_Ctrl_3), .AluResult(AluResult_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data_3),
    .rsp_rd(rsp_rd_3), .rsp_err(rsp_err_3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents one command from a negedge; returns at the next negedge (cycle N+1).
  task automatic send(input bit to3, input logic [3:0] op, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                      input logic src, input logic [31:0] imm);
    cmd_op = op; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
    cmd_shamt = sh; cmd_src = src; cmd_imm = imm;
    if (to3) cmd_valid3 = 1'b1;
    else     cmd_valid  = 1'b1;
    @(negedge Clk);
    cmd_valid  = 1'b0;
    cmd_valid3 = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input logic [31:0] exp_data, input logic [4:0] exp_rd);
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid === 1'b1) break;
      @(negedge Clk);
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_data"}, rsp_data, exp_data);
    check({tag, "_rd"}, 32'(rsp_rd), 32'(exp_rd));
    check({tag, "_err"}, 32'(rsp_err), 32'd0);
    @(negedge Clk);
  endtask

  initial begin
    int wc;
    repeat (2) @(negedge Clk);
    check("rst_we", 32'(WE), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_mux", 32'(Mux_Ctrl), 32'd0);
    check("rst_rr1", 32'(RR1), 32'd0);
    check("rst_rr2", 32'(RR2), 32'd0);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_aluop", 32'(AluOp), 32'd0);
    check("rst_shift", 32'(ShiftCount), 32'd0);
    check("rst_rsp_rd", 32'(rsp_rd), 32'd0);
    check("rst_wd", WD, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);
    check("rdy_after_rst", 32'(cmd_ready), 32'd1);

    // ADD r3 = r1 + r2, cycle by cycle
    send(1'b0, 4'b0010, 5'd1, 5'd2, 5'd3, 5'd0, 1'b1, 32'h0);
    check("add_read_rr1", 32'(RR1), 32'd1);
    check("add_read_rr2", 32'(RR2), 32'd2);
    check("add_read_op", 32'(AluOp), 32'b0010);
    check("add_read_we", 32'(WE), 32'd0);
    check("add_read_rdy", 32'(cmd_ready), 32'd0);
    @(negedge Clk);
    check("add_exec_we", 32'(WE), 32'd0);
    @(negedge Clk);
    check("add_wb_we", 32'(WE), 32'd1);
    check("add_wb_wr", 32'(WR), 32'd3);
    check("add_wb_mux", 32'(Mux_Ctrl), 32'd1);
    @(negedge Clk);
    check("add_rsp_valid", 32'(rsp_valid), 32'd1);
    check("add_rsp_data", rsp_data, 32'd3);
    check("add_rsp_rd", 32'(rsp_rd), 32'd3);
    check("add_rsp_we", 32'(WE), 32'd0);
    @(negedge Clk);
    check("add_idle_rdy", 32'(cmd_ready), 32'd1);
    check("add_idle_valid", 32'(rsp_valid), 32'd0);

    // literal -2 into r0
    send(1'b0, 4'b0000, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'hFFFF_FFFE);
    check("lit_we", 32'(WE), 32'd1);
    check("lit_mux", 32'(Mux_Ctrl), 32'd0);
    check("lit_wr", 32'(WR), 32'd0);
    check("lit_wd", WD, 32'hFFFF_FFFE);
    @(negedge Clk);
    check("lit_rsp_valid", 32'(rsp_valid), 32'd1);
    check("lit_rsp_data", rsp_data, 32'hFFFF_FFFE);
    check("lit_rsp_rd", 32'(rsp_rd), 32'd0);
    @(negedge Clk);

    send(1'b0, 4'b0110, 5'd0, 5'd1, 5'd5, 5'd0, 1'b1, 32'h0);
    wait_rsp("sub", 32'hFFFF_FFFD, 5'd5);
    send(1'b0, 4'b1101, 5'd4, 5'd0, 5'd6, 5'd2, 1'b1, 32'h0);
    wait_rsp("sll", 32'd16, 5'd6);
    send(1'b0, 4'b0000, 5'd0, 5'd0, 5'd8, 5'd0, 1'b0, 32'hFFFF_F830);
    wait_rsp("ld8", 32'hFFFF_F830, 5'd8);
    send(1'b0, 4'b1111, 5'd8, 5'd0, 5'd9, 5'd2, 1'b1, 32'h0);
    wait_rsp("sra", 32'hFFFF_FE0C, 5'd9);
    send(1'b0, 4'b0111, 5'd0, 5'd1, 5'd12, 5'd0, 1'b1, 32'h0);
    wait_rsp("slt", 32'd1, 5'd12);
    send(1'b0, 4'b1000, 5'd0, 5'd1, 5'd13, 5'd0, 1'b1, 32'h0);
    wait_rsp("sltu", 32'd0, 5'd13);

    // illegal op 0011
    wc = we_count;
    check("ill_rdy_before", 32'(cmd_ready), 32'd1);
    send(1'b0, 4'b0011, 5'd1, 5'd2, 5'd14, 5'd0, 1'b1, 32'h0);
    check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
    check("ill_rsp_err", 32'(rsp_err), 32'd1);
    check("ill_rsp_rd", 32'(rsp_rd), 32'd14);
    check("ill_we", 32'(WE), 32'd0);
    @(negedge Clk);
    check("ill_we_count", 32'(we_count), 32'(wc));
    check("ill_rf14", rf[14], 32'd14);
    check("ill_rdy_after", 32'(cmd_ready), 32'd1);
    send(1'b0, 4'b0001, 5'd3, 5'd6, 5'd10, 5'd0, 1'b1, 32'h0);
    wait_rsp("or", 32'd19, 5'd10);

    // EXEC_WAIT=3 instance with a 4-cycle response stall
    rsp_ready3 = 1'b0;
    send(1'b1, 4'b0010, 5'd1, 5'd2, 5'd11, 5'd0, 1'b1, 32'h0);
    check("w3_read_rr1", 32'(RR1_3), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("w3_exec_we", 32'(WE_3), 32'd0);
    end
    @(negedge Clk);
    check("w3_wb_we", 32'(WE_3), 32'd1);
    check("w3_wb_wr", 32'(WR_3), 32'd11);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check("w3_stall_valid", 32'(rsp_valid_3), 32'd1);
      check("w3_stall_data", rsp_data_3, 32'd3);
      check("w3_stall_rdy", 32'(cmd_ready_3), 32'd0);
    end
    rsp_ready3 = 1'b1;
    @(negedge Clk);
    check("w3_done_valid", 32'(rsp_valid_3), 32'd0);
    check("w3_done_rdy", 32'(cmd_ready_3), 32'd1);
    check("w3_rf11", rf3[11], 32'd3);

    // reset during EXEC of ADD r7
    wc = we_count;
    send(1'b0, 4'b0010, 5'd1, 5'd2, 5'd7, 5'd0, 1'b1, 32'h0);
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    check("arst_we", 32'(WE), 32'd0);
    check("arst_rr1", 32'(RR1), 32'd0);
    check("arst_rr2", 32'(RR2), 32'd0);
    check("arst_aluop", 32'(AluOp), 32'd0);
    check("arst_rdy", 32'(cmd_ready), 32'd0);
    repeat (2) @(negedge Clk);
    check("arst_hold_we", 32'(WE), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    Rst_n = 1'b1;
    #1;
    check("arst_rdy_release", 32'(cmd_ready), 32'd1);
    check("arst_we_count", 32'(we_count), 32'(wc));
    check("arst_rf7", rf[7], 32'd7);
    @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
